// File: rtl/alu_cmd_ctrl.sv
// Command-side initiator for the combinational alu32: valid/ready command intake,
// one registered issue stage driving the ALU, and a FWFT response FIFO with tags.
module alu_cmd_ctrl #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic             cmd_chain,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_op,
  input  logic [31:0]      alu_y,
  input  logic [3:0]       alu_flags,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_y,
  output logic [3:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [15:0]      op_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] LP_DEPTH = (CNT_W+1)'(DEPTH);
  localparam logic [3:0] LP_LAST_LEGAL_OP = 4'd8;

  // Issue stage
  logic             r_s1_valid;
  logic [31:0]      r_s1_a;
  logic [31:0]      r_s1_b;
  logic [3:0]       r_s1_op;
  logic             r_s1_chain;
  logic [TAG_W-1:0] r_s1_tag;
  logic [31:0]      r_last_y;
  logic [15:0]      r_op_count;

  // Response FIFO
  logic [31:0]      r_mem_y     [DEPTH];
  logic [3:0]       r_mem_flags [DEPTH];
  logic [TAG_W-1:0] r_mem_tag   [DEPTH];
  logic             r_mem_err   [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic             w_accept;
  logic             w_err;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic [CNT_W:0]   w_occupancy;
  logic [31:0]      w_push_y;
  logic [3:0]       w_push_flags;

  // Occupancy counts the S1 entry too, so its completion always has a free slot.
  assign w_occupancy  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid};
  assign cmd_ready    = (w_occupancy < LP_DEPTH);
  assign w_accept     = cmd_valid && cmd_ready;
  assign w_err        = (r_s1_op > LP_LAST_LEGAL_OP);
  assign w_push       = r_s1_valid;
  assign w_empty      = (r_count == '0);
  assign w_pop        = !w_empty && rsp_ready;
  assign w_push_y     = w_err ? 32'd0 : alu_y;
  assign w_push_flags = w_err ? 4'd0 : alu_flags;

  assign alu_a  = r_s1_valid ? (r_s1_chain ? r_last_y : r_s1_a) : 32'd0;
  assign alu_b  = r_s1_valid ? r_s1_b : 32'd0;
  assign alu_op = r_s1_valid ? r_s1_op : 4'd0;

  assign rsp_valid = !w_empty;
  assign rsp_y     = w_empty ? 32'd0 : r_mem_y[r_rd_ptr];
  assign rsp_flags = w_empty ? 4'd0 : r_mem_flags[r_rd_ptr];
  assign rsp_tag   = w_empty ? '0 : r_mem_tag[r_rd_ptr];
  assign rsp_err   = w_empty ? 1'b0 : r_mem_err[r_rd_ptr];
  assign op_count  = r_op_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= 32'd0;
      r_s1_b     <= 32'd0;
      r_s1_op    <= 4'd0;
      r_s1_chain <= 1'b0;
      r_s1_tag   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a     <= cmd_a;
        r_s1_b     <= cmd_b;
        r_s1_op    <= cmd_op;
        r_s1_chain <= cmd_chain;
        r_s1_tag   <= cmd_tag;
      end
    end
  end

  // last_y lands at the same edge a chained follower enters S1, so no forwarding is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_y   <= 32'd0;
      r_op_count <= 16'd0;
    end else if (r_s1_valid) begin
      if (!w_err) r_last_y <= alu_y;
      if (r_op_count != 16'hFFFF) r_op_count <= r_op_count + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_y[r_wr_ptr]     <= w_push_y;
      r_mem_flags[r_wr_ptr] <= w_push_flags;
      r_mem_tag[r_wr_ptr]   <= r_s1_tag;
      r_mem_err[r_wr_ptr]   <= w_err;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
